// File: rtl/sim_uart_mux_if.sv
// Console aggregator bundle: per-channel byte strobes in, one merged byte stream out.
// The mux itself connects through the slave modport; the byte sources and sink use master.
interface sim_uart_mux_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]   io_in_valid;
    logic [8*NUM_CH-1:0] io_in_ch;
    logic                io_out_valid;
    logic                io_out_ready;
    logic [7:0]          io_out_ch;
    logic [CHW-1:0]      io_out_chan;
    logic                io_out_last;
    logic [31:0]         io_drop_cnt;
    logic                io_busy;

    modport master (
        output io_in_valid, io_in_ch, io_out_ready,
        input  io_out_valid, io_out_ch, io_out_chan, io_out_last, io_drop_cnt, io_busy
    );

    modport slave (
        input  io_in_valid, io_in_ch, io_out_ready,
        output io_out_valid, io_out_ch, io_out_chan, io_out_last, io_drop_cnt, io_busy
    );
endinterface

// File: rtl/sim_uart_mux.sv
// Multi-channel console aggregator: buffers each channel's bytes and emits whole lines
// (or forced flushes of partial lines) one channel at a time on a valid/ready stream.
module sim_uart_mux #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned IDLE_FLUSH = 1024
) (
    input logic           clock,
    input logic           reset,
    sim_uart_mux_if.slave bus
);
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned IW  = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;

    localparam logic [7:0]    NL       = 8'h0A;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_FLUSH);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    // Per-channel FIFO storage and bookkeeping
    logic [7:0]    mem    [NUM_CH][DEPTH];
    logic [AW-1:0] wr_ptr [NUM_CH];
    logic [AW-1:0] rd_ptr [NUM_CH];
    logic [AW:0]   cnt    [NUM_CH];
    logic [AW:0]   nl     [NUM_CH];
    logic [IW-1:0] idle   [NUM_CH];

    // Arbiter state
    state_e         state;
    logic [CHW-1:0] gnt;
    logic [CHW-1:0] rr_ptr;
    logic           mode_nl;
    logic [AW:0]    len;
    logic [31:0]    drop_cnt;

    logic [7:0]        head [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] elig;
    logic [7:0]        gnt_head;
    logic              hs;
    logic              last;
    logic              any_elig;
    logic [CHW-1:0]    pick;
    logic [32:0]       drop_sum;

    assign hs       = (state == StSend) && bus.io_out_ready;
    assign gnt_head = head[gnt];
    // Forced flushes end on a byte count so bytes arriving mid-flush wait for a later grant
    assign last     = (state == StSend) && (mode_nl ? (gnt_head == NL) : (len == CNT_ONE));

    // Per-channel status: head byte, full, accepted push, pop and flush eligibility
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            head[i] = mem[i][rd_ptr[i]];
            full[i] = (cnt[i] == CNT_FULL);
            push[i] = bus.io_in_valid[i] && !full[i];
            pop[i]  = hs && (gnt == CHW'(i));
            elig[i] = (nl[i] != '0) || full[i] ||
                      ((IDLE_FLUSH != 0) && (idle[i] >= IDLE_LIM) && (cnt[i] != '0));
        end
    end

    // Round-robin pick: first eligible channel strictly after the last one served
    always_comb begin
        int unsigned idx;
        idx      = 0;
        any_elig = 1'b0;
        pick     = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                pick     = CHW'(idx);
            end
        end
    end

    // Saturating drop counter next value; at most NUM_CH drops per cycle
    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < NUM_CH; i++) begin
            drop_sum = drop_sum + 33'(bus.io_in_valid[i] && full[i]);
        end
    end

    // FIFO data array; pointers alone define contents, so no reset needed here
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= bus.io_in_ch[8*i +: 8];
            end
        end
    end

    // Per-channel pointers, occupancy, newline count and idle timer
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
                nl[i]     <= '0;
                idle[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                cnt[i] <= cnt[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
                nl[i]  <= nl[i]
                          + (AW + 1)'(push[i] && (bus.io_in_ch[8*i +: 8] == NL))
                          - (AW + 1)'(pop[i] && (head[i] == NL));
                if (bus.io_in_valid[i]) begin
                    idle[i] <= '0;
                end else if (idle[i] < IDLE_LIM) begin
                    idle[i] <= idle[i] + 1'b1;
                end
            end
        end
    end

    // Arbiter FSM: grant a channel, stream one line or forced flush, then return to idle
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StIdle;
            gnt      <= '0;
            rr_ptr   <= CHW'(NUM_CH - 1);
            mode_nl  <= 1'b0;
            len      <= '0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            case (state)
                StIdle: begin
                    if (any_elig) begin
                        gnt     <= pick;
                        rr_ptr  <= pick;
                        mode_nl <= (nl[pick] != '0);
                        len     <= cnt[pick];
                        state   <= StSend;
                    end
                end
                StSend: begin
                    if (hs) begin
                        if (!mode_nl) begin
                            len <= len - 1'b1;
                        end
                        if (last) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.io_out_valid = (state == StSend);
    assign bus.io_out_ch    = (state == StSend) ? gnt_head : 8'h00;
    assign bus.io_out_chan  = (state == StSend) ? gnt : '0;
    assign bus.io_out_last  = last;
    assign bus.io_drop_cnt  = drop_cnt;
    assign bus.io_busy      = (state == StSend);
endmodule

// File: tb/tb_sim_uart_mux.sv
// Bench for sim_uart_mux: directed line/flush/reset scenarios plus a randomized run
// scored against per-channel byte queues.
module tb_sim_uart_mux;
    logic clock;
    logic reset;

    sim_uart_mux_if #(.NUM_CH(4)) bus_a ();
    sim_uart_mux_if #(.NUM_CH(4)) bus_b ();

    sim_uart_mux #(.NUM_CH(4), .DEPTH(8), .IDLE_FLUSH(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    sim_uart_mux #(.NUM_CH(4), .DEPTH(8), .IDLE_FLUSH(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] c;
        logic       l;
    } beat_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    beat_t       obs[$];
    logic [7:0]  exp_q[4][$];
    bit          rand_mode = 1'b0;
    bit          in_line   = 1'b0;
    logic [1:0]  line_ch   = '0;
    bit          b_seen    = 1'b0;
    int          rr_model  = 3;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Channel that round-robin serves first among two, given the last channel served
    function automatic int first_after(input int rr, input int a, input int b);
        return (((a - rr - 1 + 8) % 4) <= ((b - rr - 1 + 8) % 4)) ? a : b;
    endfunction

    task automatic push_str(input int ch, input string s);
        for (int k = 0; k < s.len(); k++) begin
            bus_a.io_in_valid            = 4'(1 << ch);
            bus_a.io_in_ch               = '0;
            bus_a.io_in_ch[8*ch +: 8]    = s[k];
            tick();
        end
        bus_a.io_in_valid = '0;
        bus_a.io_in_ch    = '0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (obs.size() < n && c < budget) begin
            tick();
            c++;
        end
        check_eq({tag, "_arrived"}, 32'(obs.size() >= n), 32'd1);
    endtask

    task automatic check_line(input string tag, input int base, input int ch, input string s);
        for (int k = 0; k < s.len(); k++) begin
            if (base + k >= obs.size()) begin
                check_eq({tag, "_count"}, 32'(obs.size()), 32'(base + k + 1));
                break;
            end
            check_eq({tag, "_byte"}, 32'(obs[base+k].b), 32'(s[k]));
            check_eq({tag, "_chan"}, 32'(obs[base+k].c), 32'(ch));
            check_eq({tag, "_last"}, 32'(obs[base+k].l), 32'(k == s.len() - 1));
        end
    endtask

    // Two lines completing on the same cycle must come out whole, in round-robin order
    task automatic same_cycle_lines(input string tag);
        string s0, s1;
        int    f, o;
        s0 = "ab\n";
        s1 = "cd\n";
        obs.delete();
        f = first_after(rr_model, 0, 1);
        o = (f == 0) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            bus_a.io_in_valid     = 4'b0011;
            bus_a.io_in_ch        = '0;
            bus_a.io_in_ch[7:0]   = s0[k];
            bus_a.io_in_ch[15:8]  = s1[k];
            tick();
        end
        bus_a.io_in_valid = '0;
        bus_a.io_in_ch    = '0;
        wait_obs(6, 40, tag);
        check_line({tag, "_first"}, 0, f, (f == 0) ? s0 : s1);
        check_line({tag, "_second"}, 3, o, (o == 0) ? s0 : s1);
        rr_model = o;
    endtask

    // Monitor: records accepted beats; in the random phase scores them against the queues
    initial begin
        forever begin
            @(negedge clock);
            if (bus_b.io_out_valid) b_seen = 1'b1;
            if (bus_a.io_out_valid && bus_a.io_out_ready) begin
                obs.push_back({bus_a.io_out_ch, bus_a.io_out_chan, bus_a.io_out_last});
                if (rand_mode) begin
                    logic [1:0] c;
                    c = bus_a.io_out_chan;
                    if (in_line) check_eq("rand_contig_chan", 32'(c), 32'(line_ch));
                    check_eq("rand_expected_data", 32'(exp_q[c].size() != 0), 32'd1);
                    if (exp_q[c].size() != 0) begin
                        check_eq("rand_byte", 32'(bus_a.io_out_ch), 32'(exp_q[c].pop_front()));
                    end
                    if (bus_a.io_out_ch == 8'h0A) begin
                        check_eq("rand_nl_last", 32'(bus_a.io_out_last), 32'd1);
                    end
                    in_line = !bus_a.io_out_last;
                    line_ch = c;
                end
            end
        end
    end

    initial begin
        bit done;
        int budget;
        reset              = 1'b1;
        bus_a.io_in_valid  = '0;
        bus_a.io_in_ch     = '0;
        bus_a.io_out_ready = 1'b1;
        bus_b.io_in_valid  = '0;
        bus_b.io_in_ch     = '0;
        bus_b.io_out_ready = 1'b1;
        repeat (3) tick();

        check_eq("rst_valid", 32'(bus_a.io_out_valid), 32'd0);
        check_eq("rst_ch",    32'(bus_a.io_out_ch),    32'd0);
        check_eq("rst_chan",  32'(bus_a.io_out_chan),  32'd0);
        check_eq("rst_last",  32'(bus_a.io_out_last),  32'd0);
        check_eq("rst_busy",  32'(bus_a.io_busy),      32'd0);
        check_eq("rst_drop",  bus_a.io_drop_cnt,       32'd0);
        reset = 1'b0;
        tick();

        // Same-cycle lines straight after reset, then again from the updated pointer
        same_cycle_lines("pair_a");
        same_cycle_lines("pair_b");

        // Single line with grant latency
        obs.delete();
        push_str(0, "hi\n");
        check_eq("single_lat_e", 32'(bus_a.io_out_valid), 32'd0);
        tick();
        check_eq("single_lat_e1", 32'(bus_a.io_out_valid), 32'd1);
        wait_obs(3, 20, "single");
        check_line("single", 0, 0, "hi\n");
        rr_model = 0;

        // With the pointer at channel 0, channel 1 must win the tie
        same_cycle_lines("pair_c");

        // Backpressure holds the second byte stable
        obs.delete();
        bus_a.io_out_ready = 1'b0;
        push_str(3, "xyz\n");
        tick();
        check_eq("bp_valid_up", 32'(bus_a.io_out_valid), 32'd1);
        bus_a.io_out_ready = 1'b1;
        tick();
        bus_a.io_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_hold_valid", 32'(bus_a.io_out_valid), 32'd1);
            check_eq("bp_hold_byte",  32'(bus_a.io_out_ch),    32'h79);
            check_eq("bp_hold_chan",  32'(bus_a.io_out_chan),  32'd3);
            check_eq("bp_hold_last",  32'(bus_a.io_out_last),  32'd0);
            tick();
        end
        bus_a.io_out_ready = 1'b1;
        wait_obs(4, 20, "bp");
        check_line("bp", 0, 3, "xyz\n");
        rr_model = 3;

        // Full FIFO: eight bytes force a flush, the ninth arrives while full and is dropped
        obs.delete();
        push_str(0, "ABCDEFGHI");
        wait_obs(8, 30, "full");
        check_line("full", 0, 0, "ABCDEFGH");
        repeat (30) tick();
        check_eq("full_no_extra", 32'(obs.size()), 32'd8);
        check_eq("full_drop", bus_a.io_drop_cnt, 32'd1);
        rr_model = 0;

        // Idle flush of a partial line after 16 quiet cycles
        obs.delete();
        push_str(1, "ab");
        repeat (16) tick();
        check_eq("idle_not_yet", 32'(bus_a.io_out_valid), 32'd0);
        tick();
        check_eq("idle_fire", 32'(bus_a.io_out_valid), 32'd1);
        wait_obs(2, 20, "idle");
        check_line("idle", 0, 1, "ab");
        rr_model = 1;

        // No idle flush when disabled; a newline still releases the line
        bus_b.io_in_valid = 4'b0010;
        bus_b.io_in_ch    = 32'h0000_6100;
        tick();
        bus_b.io_in_ch    = 32'h0000_6200;
        tick();
        bus_b.io_in_valid = '0;
        bus_b.io_in_ch    = '0;
        repeat (1000) tick();
        check_eq("noidle_silent", 32'(b_seen), 32'd0);
        bus_b.io_in_valid = 4'b0010;
        bus_b.io_in_ch    = 32'h0000_0A00;
        tick();
        bus_b.io_in_valid = '0;
        bus_b.io_in_ch    = '0;
        tick();
        check_eq("noidle_nl_valid", 32'(bus_b.io_out_valid), 32'd1);
        check_eq("noidle_nl_chan",  32'(bus_b.io_out_chan),  32'd1);
        check_eq("noidle_nl_byte",  32'(bus_b.io_out_ch),    32'h61);

        // Reset in the middle of a line
        obs.delete();
        push_str(0, "hello\n");
        tick();
        check_eq("rstmid_sending", 32'(bus_a.io_busy), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rstmid_valid", 32'(bus_a.io_out_valid), 32'd0);
        check_eq("rstmid_busy",  32'(bus_a.io_busy),      32'd0);
        check_eq("rstmid_drop",  bus_a.io_drop_cnt,       32'd0);
        rr_model = 3;
        obs.delete();
        push_str(2, "ok\n");
        wait_obs(3, 20, "after_rst");
        check_line("after_rst", 0, 2, "ok\n");
        repeat (30) tick();
        check_eq("after_rst_no_extra", 32'(obs.size()), 32'd3);

        // Randomized traffic with random backpressure; never lets a FIFO reach full
        obs.delete();
        in_line   = 1'b0;
        rand_mode = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus_a.io_in_valid = '0;
            bus_a.io_in_ch    = '0;
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 99) < 25 && exp_q[ch].size() < 7) begin
                    logic [7:0] b;
                    b = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
                    bus_a.io_in_valid[ch]     = 1'b1;
                    bus_a.io_in_ch[8*ch +: 8] = b;
                    exp_q[ch].push_back(b);
                end
            end
            bus_a.io_out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        bus_a.io_in_valid  = '0;
        bus_a.io_in_ch     = '0;
        bus_a.io_out_ready = 1'b1;
        done   = 1'b0;
        budget = 0;
        while (!done && budget < 600) begin
            tick();
            budget++;
            done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                   (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
        end
        check_eq("rand_drained", 32'(done), 32'd1);
        repeat (2) tick();
        check_eq("rand_idle_busy",  32'(bus_a.io_busy),      32'd0);
        check_eq("rand_idle_valid", 32'(bus_a.io_out_valid), 32'd0);
        check_eq("rand_no_drops",   bus_a.io_drop_cnt,       32'd0);
        rand_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
